// File: rtl/coeff_collector.sv
// Twiddle-coefficient collector: frames a serial coefficient stream on a start marker
// and assembles N entries into a parallel bank. Optional COEFF_COLLECTOR_DBUF_EN adds a shadow bank.
module coeff_collector #(
  parameter int NBITS = 2,
  parameter int N     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_first,
  input  logic [2*NBITS-1:0]           coeff_in,
  output logic [N*2*NBITS-1:0]         coeff_bank,
  output logic                         bank_valid,
  output logic                         frame_err,
  output logic [$clog2(N+1)-1:0]       fill
);

  localparam int CW = 2 * NBITS;
  localparam int BW = N * CW;
  localparam int FW = $clog2(N + 1);

  typedef enum logic {S_IDLE, S_LOAD} state_t;

  state_t          r_state, w_state_nxt;
  logic [FW-1:0]   r_fill, w_fill_nxt, w_wr_idx;
  logic            w_wr_en, w_done, w_err;
  logic [BW-1:0]   r_bank, w_base, w_merged;
  logic            r_bvld, r_err;

`ifdef COEFF_COLLECTOR_DBUF_EN
  logic [BW-1:0]   r_shadow;
  assign w_base = r_shadow;
`else
  assign w_base = r_bank;
`endif

  // Framing decisions for the current sample
  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    w_wr_en     = 1'b0;
    w_wr_idx    = '0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    if (in_valid) begin
      if (in_first) begin
        w_wr_en = 1'b1;
        w_err   = (r_state == S_LOAD);
        if (N == 1) begin
          w_done      = 1'b1;
          w_fill_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_fill_nxt  = FW'(1);
          w_state_nxt = S_LOAD;
        end
      end else if (r_state == S_LOAD) begin
        w_wr_en  = 1'b1;
        w_wr_idx = r_fill;
        if (r_fill == FW'(N - 1)) begin
          w_done      = 1'b1;
          w_fill_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_fill_nxt = r_fill + FW'(1);
        end
      end else begin
        w_err = 1'b1;
      end
    end
  end

  // Entry 0 lives in the MSBs of the bank
  always_comb begin
    w_merged = w_base;
    for (int k = 0; k < N; k++) begin
      if (w_wr_en && (w_wr_idx == FW'(k)))
        w_merged[BW-1-k*CW -: CW] = coeff_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_fill  <= '0;
      r_bvld  <= 1'b0;
      r_err   <= 1'b0;
      r_bank  <= '0;
`ifdef COEFF_COLLECTOR_DBUF_EN
      r_shadow <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_fill  <= w_fill_nxt;
      r_bvld  <= w_done;
      r_err   <= w_err;
`ifdef COEFF_COLLECTOR_DBUF_EN
      if (w_wr_en) r_shadow <= w_merged;
      if (w_done)  r_bank   <= w_merged;
`else
      if (w_wr_en) r_bank <= w_merged;
`endif
    end
  end

  assign coeff_bank = r_bank;
  assign bank_valid = r_bvld;
  assign frame_err  = r_err;
  assign fill       = r_fill;

endmodule

// File: tb/tb_coeff_collector.sv
// Self-checking bench for coeff_collector (NBITS=2, N=8): vector table plus hand-written
// sequences for reset, abort and bank-buffering behaviour; completed banks go through a queue.
module tb_coeff_collector;

  localparam int NBITS = 2;
  localparam int N     = 8;
  localparam int CW    = 4;
  localparam int BW    = 32;
  localparam int FW    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_first;
  logic [CW-1:0]   coeff_in;
  logic [BW-1:0]   coeff_bank;
  logic            bank_valid;
  logic            frame_err;
  logic [FW-1:0]   fill;

  coeff_collector #(.NBITS(NBITS), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_first   (in_first),
    .coeff_in   (coeff_in),
    .coeff_bank (coeff_bank),
    .bank_valid (bank_valid),
    .frame_err  (frame_err),
    .fill       (fill)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            v;
    bit            f;
    logic [CW-1:0] d;
    bit            ebv;
    bit            eerr;
    logic [FW-1:0] efill;
    bit            chkb;
    logic [BW-1:0] ebank;
  } vec_t;

  vec_t          tbl[$];
  logic [BW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            n_bv_seen = 0;
  int            n_bv_exp = 0;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic add(input bit v, input bit f, input logic [CW-1:0] d, input bit ebv,
                     input bit eerr, input logic [FW-1:0] efill, input bit chkb,
                     input logic [BW-1:0] ebank);
    vec_t r;
    r.v = v; r.f = f; r.d = d; r.ebv = ebv; r.eerr = eerr;
    r.efill = efill; r.chkb = chkb; r.ebank = ebank;
    tbl.push_back(r);
  endtask

  task automatic drive(input bit v, input bit f, input logic [CW-1:0] d, input bit ebv,
                       input bit eerr, input logic [FW-1:0] efill, input bit chkb,
                       input logic [BW-1:0] ebank, input string nm);
    in_valid = v;
    in_first = f;
    coeff_in = d;
    if (ebv) begin
      exp_q.push_back(ebank);
      n_bv_exp++;
    end
    @(posedge clk);
    #1;
    chk({nm, "_bv"}, BW'(bank_valid), BW'(ebv));
    chk({nm, "_err"}, BW'(frame_err), BW'(eerr));
    chk({nm, "_fill"}, BW'(fill), BW'(efill));
    if (chkb && !ebv) chk({nm, "_bank"}, coeff_bank, ebank);
  endtask

  // Completed banks are compared against the queue as they appear
  always @(posedge clk) begin
    #1;
    chk("bv_err_excl", BW'(bank_valid & frame_err), '0);
    if (bank_valid === 1'b1) begin
      n_bv_seen++;
      chk("bank_q_nonempty", BW'(exp_q.size() > 0), BW'(1));
      if (exp_q.size() > 0) chk("bank_out", coeff_bank, exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; coeff_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bank", coeff_bank, '0);
    chk("rst_bv", BW'(bank_valid), '0);
    chk("rst_err", BW'(frame_err), '0);
    chk("rst_fill", BW'(fill), '0);
    @(negedge clk);
    rst = 1'b0;

    // Partial frame then asynchronous reset mid-cycle
    drive(1, 1, 4'h9, 0, 0, 4'd1, 0, '0, "mid_a");
    drive(1, 0, 4'hA, 0, 0, 4'd2, 0, '0, "mid_b");
    drive(1, 0, 4'hB, 0, 0, 4'd3, 0, '0, "mid_c");
`ifndef COEFF_COLLECTOR_DBUF_EN
    chk("mid_direct_bank", coeff_bank, 32'h9AB0_0000);
`endif
    rst = 1'b1;
    #1;
    chk("arst_bank", coeff_bank, '0);
    chk("arst_fill", BW'(fill), '0);
    chk("arst_bv", BW'(bank_valid), '0);
    chk("arst_err", BW'(frame_err), '0);
    @(negedge clk);
    rst = 1'b0;

    // Contiguous frame 0..7
    add(1, 1, 4'h0, 0, 0, 4'd1, 0, '0);
    for (int k = 1; k < 7; k++) add(1, 0, CW'(k), 0, 0, FW'(k + 1), 0, '0);
    add(1, 0, 4'h7, 1, 0, 4'd0, 1, 32'h0123_4567);
    // Same frame with a gap after every sample
    for (int k = 0; k < 8; k++) begin
      add(1, (k == 0), CW'(k), (k == 7), 0, FW'((k + 1) % 8), 1, 32'h0123_4567);
      add(0, 0, 4'hF, 0, 0, FW'((k + 1) % 8), 0, '0);
    end
    // Short frame aborted by a fresh start marker
    add(1, 1, 4'h1, 0, 0, 4'd1, 0, '0);
    add(1, 0, 4'h2, 0, 0, 4'd2, 0, '0);
    add(1, 0, 4'h3, 0, 0, 4'd3, 0, '0);
    add(1, 1, 4'hF, 0, 1, 4'd1, 0, '0);
    for (int k = 0; k < 6; k++) add(1, 0, CW'(8 + k), 0, 0, FW'(k + 2), 0, '0);
    add(1, 0, 4'hE, 1, 0, 4'd0, 1, 32'hF89A_BCDE);
    // Stray coefficient while idle
    add(1, 0, 4'h5, 0, 1, 4'd0, 1, 32'hF89A_BCDE);
    add(0, 0, 4'h0, 0, 0, 4'd0, 1, 32'hF89A_BCDE);

    for (int i = 0; i < tbl.size(); i++)
      drive(tbl[i].v, tbl[i].f, tbl[i].d, tbl[i].ebv, tbl[i].eerr, tbl[i].efill,
            tbl[i].chkb, tbl[i].ebank, $sformatf("vec%0d", i));

    // Bank visibility while a second frame loads, including an abort
    for (int k = 0; k < 8; k++)
      drive(1, (k == 0), CW'(k), (k == 7), 0, FW'((k + 1) % 8), 0, 32'h0123_4567, "f1");
    drive(1, 1, 4'hF, 0, 0, 4'd1, 0, '0, "f2_first");
`ifdef COEFF_COLLECTOR_DBUF_EN
    chk("f2_hold0", coeff_bank, 32'h0123_4567);
`else
    chk("f2_e0_direct", BW'(coeff_bank[31:28]), BW'(4'hF));
`endif
    drive(1, 0, 4'h1, 0, 0, 4'd2, 0, '0, "f2_e1");
    drive(1, 0, 4'h2, 0, 0, 4'd3, 0, '0, "f2_e2");
    drive(0, 0, 4'h0, 0, 0, 4'd3, 0, '0, "f2_gap");
    drive(1, 1, 4'hA, 0, 1, 4'd1, 0, '0, "f2_abort");
`ifdef COEFF_COLLECTOR_DBUF_EN
    chk("f2_hold1", coeff_bank, 32'h0123_4567);
`else
    chk("f2_abort_direct", BW'(coeff_bank[31:28]), BW'(4'hA));
`endif
    for (int k = 0; k < 6; k++)
      drive(1, 0, CW'(9 - k), 0, 0, FW'(k + 2), 0, '0, "f3");
`ifdef COEFF_COLLECTOR_DBUF_EN
    chk("f3_hold", coeff_bank, 32'h0123_4567);
`endif
    drive(1, 0, 4'h3, 1, 0, 4'd0, 0, 32'hA987_6543, "f3_last");
    drive(0, 0, 4'h0, 0, 0, 4'd0, 1, 32'hA987_6543, "f3_after");

    chk("bv_count", BW'(n_bv_seen), BW'(n_bv_exp));
    chk("bank_q_drained", BW'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
